// File: rtl/load_store_unit.sv
// Load/store unit: sits between the CPU pipeline and a valid/ready data memory.
// It aligns store data into byte lanes, extracts and extends load data, rejects
// misaligned or unsupported accesses without touching memory, and bounds the
// read-return wait with a timeout that reports an error.
module load_store_unit #(
  parameter int MEM_LATENCY_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,      // active-high asynchronous reset despite the name
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        stall,
  output logic [31:0] rsp_rdata,
  output logic        done,
  output logic        error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_write,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_LATENCY_MAX + 1);
  // Counter value during the last permitted read-wait cycle
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_RWAIT = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      func3_r;
  logic [1:0]      addr_lo_r;

  // Access is legal when func3 is a supported width for the direction and the
  // address is naturally aligned for that width.
  function automatic logic access_ok(input logic wr, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~lo[0];
      3'b010:  ok = (lo == 2'b00);
      3'b100:  ok = ~wr;
      3'b101:  ok = ~wr & ~lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte-enable pattern for a store of the given width at the given lane.
  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] lo);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << lo;
      3'b001:  s = 4'b0011 << lo;
      3'b010:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Store data replicated across lanes so the strobe alone selects the target.
  function automatic logic [31:0] store_data(input logic [2:0] f3,
                                             input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      3'b010:  w = d;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Select the addressed byte/half from the returned word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      2'd3:    b = d[31:24];
      default: b = 8'h00;
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = d;
      3'b100:  r = {24'h00_0000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // The CPU is held while it presents a request, released in the completion cycle
  assign stall = req_valid & (state_r != ST_DONE);

  // Access sequencer: state, captured request, memory payload and response pulses
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      func3_r   <= 3'b000;
      addr_lo_r <= 2'b00;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= 30'h0000_0000;
      mem_wdata <= 32'h0000_0000;
      mem_wstrb <= 4'b0000;
      done      <= 1'b0;
      error     <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            if (access_ok(req_write, req_func3, req_addr[1:0])) begin
              // Capture the whole request so later input changes cannot leak in
              state_r   <= ST_REQ;
              mem_valid <= 1'b1;
              mem_write <= req_write;
              mem_addr  <= req_addr[31:2];
              mem_wdata <= req_write ? store_data(req_func3, req_wdata) : 32'h0000_0000;
              mem_wstrb <= req_write ? store_strb(req_func3, req_addr[1:0]) : 4'b0000;
              func3_r   <= req_func3;
              addr_lo_r <= req_addr[1:0];
            end else begin
              // Misaligned or unsupported: complete with error, no memory access
              state_r <= ST_DONE;
              done    <= 1'b1;
              error   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (mem_write) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
            end else begin
              state_r <= ST_RWAIT;
              cnt_r   <= '0;
            end
          end
        end
        ST_RWAIT: begin
          if (mem_rvalid) begin
            rsp_rdata <= load_extract(func3_r, addr_lo_r, mem_rdata);
            state_r   <= ST_DONE;
            done      <= 1'b1;
          end else if (cnt_r == CNT_LAST) begin
            // Memory never answered: report error with a zeroed result
            rsp_rdata <= 32'h0000_0000;
            state_r   <= ST_DONE;
            done      <= 1'b1;
            error     <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small in-bench memory responder.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_func3;
  logic        stall;
  logic [31:0] rsp_rdata;
  logic        done;
  logic        error;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_chk;
  int n_pass;

  int          dc;
  int          dn;
  logic        er;
  logic        sv;
  logic [3:0]  st;
  logic [31:0] wdv;
  logic [29:0] mav;

  load_store_unit #(.MEM_LATENCY_MAX(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_func3  (req_func3),
    .stall      (stall),
    .rsp_rdata  (rsp_rdata),
    .done       (done),
    .error      (error),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CPU access with a memory that accepts after ready_wait REQ cycles and
  // returns read data after rv_wait RWAIT cycles (rv_wait < 0: never).
  // Cycle 0 is the IDLE cycle in which the request is first presented.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input int ready_wait, input int rv_wait,
                        input logic [31:0] rdata, input logic drop_valid,
                        output int done_cyc, output int done_cnt, output logic err,
                        output logic saw_valid, output logic [3:0] strb,
                        output logic [31:0] wd, output logic [29:0] ma);
    int   req_cnt;
    int   rw_cnt;
    int   post;
    logic load_wait;
    logic hs;
    done_cyc = -1; done_cnt = 0; err = 1'b0; saw_valid = 1'b0;
    strb = 4'h0; wd = 32'h0; ma = 30'h0;
    req_cnt = 0; rw_cnt = 0; post = -1; load_wait = 1'b0; hs = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_func3 = f3;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk("stall_in_idle", {31'd0, stall}, 32'd1);
      if (hs && !wr) load_wait = 1'b1;
      hs = 1'b0;
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_valid) begin
        saw_valid = 1'b1;
        if (req_cnt >= ready_wait) begin
          mem_ready = 1'b1;
          hs = 1'b1;
          ma = mem_addr; strb = mem_wstrb; wd = mem_wdata;
        end
        req_cnt++;
      end
      if (load_wait) begin
        if (rv_wait >= 0 && rw_cnt == rv_wait) begin
          mem_rvalid = 1'b1;
          load_wait = 1'b0;
        end
        rw_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = c;
          err = error;
          chk("stall_in_done", {31'd0, stall}, 32'd0);
          req_valid = 1'b0;
          post = c + 2;
        end
      end
      if (c >= 1) begin
        // Scramble request inputs: the in-flight access must not notice
        req_addr = ~addr; req_wdata = ~wdata; req_func3 = 3'b010;
        if (drop_valid && done_cyc < 0) req_valid = 1'b0;
      end
      if (c == post) break;
    end
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_func3 = 3'b000; mem_ready = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'h0);
    chk("rst_addr", {2'd0, mem_addr}, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b0;

    // SW 0x10 with immediate ready
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("sw_done_cycle", dc, 32'd2);
    chk("sw_done_count", dn, 32'd1);
    chk("sw_error", {31'd0, er}, 32'd0);
    chk("sw_mem_addr", {2'd0, mav}, 32'h4);
    chk("sw_wstrb", {28'd0, st}, 32'hF);
    chk("sw_wdata", wdv, 32'hDEAD_BEEF);

    // LB 0x23, read data after 3 wait cycles
    access(1'b0, 32'h0000_0023, 32'h0, 3'b000, 0, 3, 32'h80FF_1234, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    chk("lb_done_count", dn, 32'd1);
    chk("lb_error", {31'd0, er}, 32'd0);
    chk("lb_done_cycle", dc, 32'd6);
    chk("lb_mem_addr", {2'd0, mav}, 32'h8);

    // LHU 0x22
    access(1'b0, 32'h0000_0022, 32'h0, 3'b101, 0, 0, 32'h80FF_1234, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("lhu_rdata", rsp_rdata, 32'h0000_80FF);
    chk("lhu_done_cycle", dc, 32'd3);

    // SB 0x21; load result must survive the store
    access(1'b1, 32'h0000_0021, 32'h0000_00AB, 3'b000, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("sb_wstrb", {28'd0, st}, 32'h2);
    chk("sb_wdata", wdv, 32'hABAB_ABAB);
    chk("sb_keeps_rdata", rsp_rdata, 32'h0000_80FF);

    // SH 0x02 with two cycles of back-pressure
    access(1'b1, 32'h0000_0002, 32'h0000_1234, 3'b001, 2, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("sh_wstrb", {28'd0, st}, 32'hC);
    chk("sh_wdata", wdv, 32'h1234_1234);
    chk("sh_done_cycle", dc, 32'd4);
    chk("sh_mem_addr", {2'd0, mav}, 32'h0);

    // LH 0x00 with req_valid dropped mid-access
    access(1'b0, 32'h0000_0000, 32'h0, 3'b001, 0, 1, 32'h1234_ABCD, 1'b1, dc, dn, er, sv, st, wdv, mav);
    chk("lh_drop_rdata", rsp_rdata, 32'hFFFF_ABCD);
    chk("lh_drop_done_count", dn, 32'd1);
    chk("lh_drop_done_cycle", dc, 32'd4);

    // LW 0x06 misaligned
    access(1'b0, 32'h0000_0006, 32'h0, 3'b010, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("lw_mis_no_access", {31'd0, sv}, 32'd0);
    chk("lw_mis_done_cycle", dc, 32'd1);
    chk("lw_mis_error", {31'd0, er}, 32'd1);
    chk("lw_mis_done_count", dn, 32'd1);
    chk("lw_mis_keeps_rdata", rsp_rdata, 32'hFFFF_ABCD);

    // Unsupported func3 011
    access(1'b0, 32'h0000_0000, 32'h0, 3'b011, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("f3_011_no_access", {31'd0, sv}, 32'd0);
    chk("f3_011_error", {31'd0, er}, 32'd1);

    // SH to odd address
    access(1'b1, 32'h0000_0001, 32'h0000_5555, 3'b001, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("sh_mis_no_access", {31'd0, sv}, 32'd0);
    chk("sh_mis_error", {31'd0, er}, 32'd1);

    // LW with no read return: timeout after 15 RWAIT cycles
    access(1'b0, 32'h0000_0040, 32'h0, 3'b010, 0, -1, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("tmo_done_cycle", dc, 32'd17);
    chk("tmo_error", {31'd0, er}, 32'd1);
    chk("tmo_rdata", rsp_rdata, 32'h0);
    chk("tmo_done_count", dn, 32'd1);

    // Plain LW to leave a nonzero result before the reset test
    access(1'b0, 32'h0000_0044, 32'h0, 3'b010, 0, 0, 32'hCAFE_F00D, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("lw_rdata", rsp_rdata, 32'hCAFE_F00D);
    chk("lw_error", {31'd0, er}, 32'd0);

    // Reset asserted while waiting for read data
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0048; req_func3 = 3'b010;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_async_rdata", rsp_rdata, 32'h0);
    chk("rst_async_mem_valid", {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (i == 1) mem_rvalid = 1'b0;
    end
    chk("rst_mid_no_done", dn, 32'd0);
    chk("rst_mid_rdata", rsp_rdata, 32'h0);
    chk("rst_mid_mem_valid", {31'd0, mem_valid}, 32'd0);

    // A fresh store starts from IDLE
    access(1'b1, 32'h0000_0010, 32'h0102_0304, 3'b010, 0, 0, 32'h0, 1'b0, dc, dn, er, sv, st, wdv, mav);
    chk("post_rst_done_cycle", dc, 32'd2);
    chk("post_rst_wdata", wdv, 32'h0102_0304);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
